t03_request_unit_sb: RTL and testbench

- Parametrised successor to the team's cached request unit.
- Arbitrates one bus master port between three requesters: instruction-fetch misses, data loads, and data stores.
- Stores are posted into a SB_DEPTH-entry FIFO store buffer, so the pipeline does not stall on writes; the buffer drains whenever the bus is free.
- Sits between the core pipeline / I-cache and the wishbone manager / MMIO.

---
 rtl/t03_request_unit_sb_if.sv | 23 ++
 rtl/t03_request_unit_sb.sv | 148 ++++++++++++++
 tb/tb_t03_request_unit_sb.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/t03_request_unit_sb_if.sv
// Bus-side handshake of the request unit: request strobes, address/data/byte-enables
// towards the wishbone manager and the single-cycle ack back.
interface t03_request_unit_sb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  read;
  logic                  write;
  logic                  ack;
  logic [ADDR_W-1:0]     address;
  logic [DATA_W-1:0]     bus_wdata;
  logic [DATA_W/8-1:0]   bus_sel;

  modport master (
    output read, write, address, bus_wdata, bus_sel,
    input  ack
  );

  modport slave (
    input  read, write, address, bus_wdata, bus_sel,
    output ack
  );
endinterface

// File: rtl/t03_request_unit_sb.sv
// Request unit arbitrating I-fetch misses, loads and posted stores onto one bus
// master; stores go through a FIFO store buffer drained when the bus is free.
module t03_request_unit_sb #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int SB_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         nrst,
  t03_request_unit_sb_if.master        bus,
  input  logic                         next_hit,
  input  logic                         memRead,
  input  logic                         memWrite,
  input  logic [ADDR_W-1:0]            pcMemory,
  input  logic [ADDR_W-1:0]            resultALU,
  input  logic [DATA_W-1:0]            storeData,
  input  logic [DATA_W/8-1:0]          storeSel,
  output logic                         freezePC,
  output logic                         freezeInstr,
  output logic                         addressSrc,
  output logic                         cache_fill,
  output logic                         sb_full,
  output logic [$clog2(SB_DEPTH):0]    sb_count
);
  localparam int PW    = $clog2(SB_DEPTH);
  localparam int CW    = PW + 1;
  localparam int SEL_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     head, tail;
  logic [CW-1:0]     count;
  logic              push, pop, push_ok, fr_pc, fr_in;

  logic [ADDR_W-1:0] fifo_addr [SB_DEPTH];
  logic [DATA_W-1:0] fifo_data [SB_DEPTH];
  logic [SEL_W-1:0]  fifo_sel  [SB_DEPTH];

  assign sb_count = count;
  assign sb_full  = (count == CW'(SB_DEPTH));

  always_comb begin
    state_nxt = state;
    fr_pc     = 1'b0;
    fr_in     = 1'b0;
    push_ok   = 1'b0;
    unique case (state)
      IDLE: begin
        push_ok = 1'b1;
        if (memWrite && sb_full) begin
          state_nxt = DRAIN;
          fr_pc     = 1'b1;
          fr_in     = 1'b1;
        end else if (memRead && (count != '0)) begin
          state_nxt = DRAIN;
          fr_pc     = 1'b1;
          fr_in     = 1'b1;
        end else if (memRead) begin
          state_nxt = LOAD;
          fr_pc     = 1'b1;
          fr_in     = 1'b1;
        end else if (!next_hit) begin
          state_nxt = FETCH;
          fr_pc     = 1'b1;
        end else if (count != '0) begin
          state_nxt = DRAIN;
        end
      end
      FETCH: begin
        fr_in = 1'b1;
        fr_pc = !bus.ack;
        if (bus.ack) state_nxt = IDLE;
      end
      LOAD: begin
        fr_pc = 1'b1;
        fr_in = 1'b1;
        if (bus.ack) state_nxt = next_hit ? IDLE : FETCH;
      end
      DRAIN: begin
        push_ok = 1'b1;
        fr_pc   = memRead | !next_hit | (memWrite & sb_full);
        fr_in   = fr_pc;
        if (bus.ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Freeze outputs are forced low while reset is asserted, independent of inputs.
  assign freezePC    = fr_pc & nrst;
  assign freezeInstr = fr_in & nrst;
  assign push        = push_ok & memWrite & ~sb_full & ~fr_in;
  assign pop         = (state == DRAIN) & bus.ack;

  always_comb begin
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    bus.address   = pcMemory;
    bus.bus_wdata = '0;
    bus.bus_sel   = '0;
    addressSrc    = 1'b0;
    unique case (state)
      FETCH: begin
        bus.read    = 1'b1;
        bus.bus_sel = '1;
      end
      LOAD: begin
        bus.read    = 1'b1;
        bus.address = resultALU;
        bus.bus_sel = '1;
        addressSrc  = 1'b1;
      end
      DRAIN: begin
        bus.write     = 1'b1;
        bus.address   = fifo_addr[head];
        bus.bus_wdata = fifo_data[head];
        bus.bus_sel   = fifo_sel[head];
        addressSrc    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      cache_fill <= 1'b0;
    end else begin
      state      <= state_nxt;
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count      <= count + CW'(push) - CW'(pop);
      cache_fill <= (state == FETCH) && bus.ack;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[tail] <= resultALU;
      fifo_data[tail] <= storeData;
      fifo_sel[tail]  <= storeSel;
    end
  end
endmodule

// File: tb/tb_t03_request_unit_sb.sv
// Directed bench for t03_request_unit_sb with hand-computed expectations.
module tb_t03_request_unit_sb;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int SB_DEPTH = 4;

  logic        clk = 1'b0;
  logic        nrst;
  logic        next_hit, memRead, memWrite;
  logic [31:0] pcMemory, resultALU, storeData;
  logic [3:0]  storeSel;
  logic        freezePC, freezeInstr, addressSrc, cache_fill, sb_full;
  logic [2:0]  sb_count;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] st_addr [5] = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};
  logic [31:0] st_data [5] = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0004};
  logic [3:0]  st_sel  [5] = '{4'h1, 4'h3, 4'hF, 4'h8, 4'h6};

  t03_request_unit_sb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  t03_request_unit_sb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SB_DEPTH(SB_DEPTH)) dut (
    .clk(clk), .nrst(nrst), .bus(bus),
    .next_hit(next_hit), .memRead(memRead), .memWrite(memWrite),
    .pcMemory(pcMemory), .resultALU(resultALU), .storeData(storeData), .storeSel(storeSel),
    .freezePC(freezePC), .freezeInstr(freezeInstr), .addressSrc(addressSrc),
    .cache_fill(cache_fill), .sb_full(sb_full), .sb_count(sb_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    memWrite  = 1'b1;
    resultALU = a;
    storeData = d;
    storeSel  = s;
  endtask

  initial begin
    nrst = 1'b1; bus.ack = 1'b0; next_hit = 1'b1; memRead = 1'b0; memWrite = 1'b0;
    pcMemory = 32'h40; resultALU = '0; storeData = '0; storeSel = '0;
    #1 nrst = 1'b0;
    #2;
    chk("rst_read",   64'(bus.read), 64'd0);
    chk("rst_write",  64'(bus.write), 64'd0);
    chk("rst_frz",    64'(freezePC), 64'd0);
    chk("rst_addr",   64'(bus.address), 64'h40);
    chk("rst_cnt",    64'(sb_count), 64'd0);
    chk("rst_fill",   64'(cache_fill), 64'd0);
    tick();
    nrst = 1'b1;
    tick();

    // Store stream: fill buffer, then a fifth store blocks until one entry drains
    for (int i = 0; i < 4; i++) begin
      put(st_addr[i], st_data[i], st_sel[i]);
      #1;
      chk("st_nofrz", 64'(freezePC), 64'd0);
      tick();
    end
    put(st_addr[4], st_data[4], st_sel[4]);
    #1;
    chk("st_cnt4",  64'(sb_count), 64'd4);
    chk("st_full",  64'(sb_full), 64'd1);
    chk("st_write", 64'(bus.write), 64'd1);
    chk("st_asrc",  64'(addressSrc), 64'd1);
    chk("st_addr0", 64'(bus.address), 64'h100);
    chk("st_data0", 64'(bus.bus_wdata), 64'hA000_0000);
    chk("st_sel0",  64'(bus.bus_sel), 64'h1);
    chk("st_frzpc", 64'(freezePC), 64'd1);
    chk("st_frzin", 64'(freezeInstr), 64'd1);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    #1;
    chk("st_gap_wr",  64'(bus.write), 64'd0);
    chk("st_gap_frz", 64'(freezePC), 64'd0);
    chk("st_gap_cnt", 64'(sb_count), 64'd3);
    tick();
    memWrite = 1'b0;
    for (int j = 1; j < 5; j++) begin
      #1;
      chk("dr_write", 64'(bus.write), 64'd1);
      chk("dr_addr",  64'(bus.address), 64'(st_addr[j]));
      chk("dr_data",  64'(bus.bus_wdata), 64'(st_data[j]));
      chk("dr_sel",   64'(bus.bus_sel), 64'(st_sel[j]));
      bus.ack = 1'b1;
      tick();
      bus.ack = 1'b0;
      #1;
      chk("dr_idle", 64'(bus.write), 64'd0);
      chk("dr_cnt",  64'(sb_count), 64'(4 - j));
      tick();
    end

    // Load after two buffered stores: stores drain first, then the load
    put(32'h100, 32'hB0, 4'h3);
    tick();
    put(32'h104, 32'hB1, 4'hC);
    tick();
    memWrite = 1'b0; memRead = 1'b1; resultALU = 32'h200;
    #1;
    chk("ld_d0_addr", 64'(bus.address), 64'h100);
    chk("ld_d0_wr",   64'(bus.write), 64'd1);
    chk("ld_d0_frz",  64'(freezePC), 64'd1);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    #1;
    chk("ld_i0_frz", 64'(freezePC), 64'd1);
    chk("ld_i0_cnt", 64'(sb_count), 64'd1);
    tick();
    #1;
    chk("ld_d1_addr", 64'(bus.address), 64'h104);
    chk("ld_d1_data", 64'(bus.bus_wdata), 64'hB1);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    #1;
    chk("ld_i1_frz", 64'(freezePC), 64'd1);
    chk("ld_i1_wr",  64'(bus.write), 64'd0);
    tick();
    chk("ld_read", 64'(bus.read), 64'd1);
    chk("ld_addr", 64'(bus.address), 64'h200);
    chk("ld_asrc", 64'(addressSrc), 64'd1);
    chk("ld_sel",  64'(bus.bus_sel), 64'hF);
    bus.ack = 1'b1;
    #1;
    chk("ld_ack_frz", 64'(freezePC), 64'd1);
    tick();
    bus.ack = 1'b0; memRead = 1'b0;
    #1;
    chk("ld_done_rd",  64'(bus.read), 64'd0);
    chk("ld_done_frz", 64'(freezePC), 64'd0);

    // Fetch miss with ack on the third FETCH cycle
    pcMemory = 32'h40; next_hit = 1'b0;
    #1;
    chk("fm_frzpc", 64'(freezePC), 64'd1);
    chk("fm_frzin", 64'(freezeInstr), 64'd0);
    chk("fm_rd0",   64'(bus.read), 64'd0);
    tick();
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) bus.ack = 1'b1;
      #1;
      chk("fm_read",  64'(bus.read), 64'd1);
      chk("fm_asrc",  64'(addressSrc), 64'd0);
      chk("fm_addr",  64'(bus.address), 64'h40);
      chk("fm_frzin", 64'(freezeInstr), 64'd1);
      chk("fm_frzpc", 64'(freezePC), (c == 3) ? 64'd0 : 64'd1);
      chk("fm_fill0", 64'(cache_fill), 64'd0);
      tick();
    end
    bus.ack = 1'b0; next_hit = 1'b1;
    #1;
    chk("fm_fill1", 64'(cache_fill), 64'd1);
    chk("fm_idle",  64'(bus.read), 64'd0);
    tick();
    chk("fm_fill2", 64'(cache_fill), 64'd0);

    // Simultaneous push and pop in DRAIN at two entries
    put(32'h300, 32'hC0, 4'h1);
    tick();
    put(32'h304, 32'hC1, 4'h2);
    tick();
    put(32'h308, 32'hC2, 4'h4);
    bus.ack = 1'b1;
    #1;
    chk("pp_cnt_pre", 64'(sb_count), 64'd2);
    chk("pp_addr",    64'(bus.address), 64'h300);
    chk("pp_nofrz",   64'(freezePC), 64'd0);
    tick();
    memWrite = 1'b0; bus.ack = 1'b0;
    #1;
    chk("pp_cnt_post", 64'(sb_count), 64'd2);
    tick();
    #1;
    chk("pp_next_addr", 64'(bus.address), 64'h304);
    chk("pp_next_data", 64'(bus.bus_wdata), 64'hC1);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    tick();
    #1;
    chk("pp_tail_addr", 64'(bus.address), 64'h308);
    chk("pp_tail_data", 64'(bus.bus_wdata), 64'hC2);
    chk("pp_tail_sel",  64'(bus.bus_sel), 64'h4);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    #1;
    chk("pp_empty", 64'(sb_count), 64'd0);
    tick();

    // Load ack with a pending I-cache miss goes straight to FETCH
    memRead = 1'b1; resultALU = 32'h400;
    tick();
    chk("lf_read", 64'(bus.read), 64'd1);
    chk("lf_addr", 64'(bus.address), 64'h400);
    bus.ack = 1'b1; next_hit = 1'b0; pcMemory = 32'h80;
    tick();
    bus.ack = 1'b0; memRead = 1'b0;
    #1;
    chk("lf_f_read", 64'(bus.read), 64'd1);
    chk("lf_f_addr", 64'(bus.address), 64'h80);
    chk("lf_f_asrc", 64'(addressSrc), 64'd0);
    chk("lf_f_fill", 64'(cache_fill), 64'd0);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0; next_hit = 1'b1;
    #1;
    chk("lf_fill", 64'(cache_fill), 64'd1);
    tick();

    // Asynchronous reset in the middle of a drain with three entries
    put(32'h500, 32'hD0, 4'h1);
    tick();
    put(32'h504, 32'hD1, 4'h2);
    tick();
    put(32'h508, 32'hD2, 4'h4);
    tick();
    memWrite = 1'b0;
    #1;
    chk("ar_cnt3",  64'(sb_count), 64'd3);
    chk("ar_write", 64'(bus.write), 64'd1);
    nrst = 1'b0; memRead = 1'b1;
    #1;
    chk("ar_wr0",   64'(bus.write), 64'd0);
    chk("ar_rd0",   64'(bus.read), 64'd0);
    chk("ar_frzpc", 64'(freezePC), 64'd0);
    chk("ar_frzin", 64'(freezeInstr), 64'd0);
    chk("ar_cnt0",  64'(sb_count), 64'd0);
    chk("ar_addr",  64'(bus.address), 64'h80);
    chk("ar_asrc",  64'(addressSrc), 64'd0);
    memRead = 1'b0;
    tick();
    nrst = 1'b1;
    #1;
    chk("ar_rel_cnt",  64'(sb_count), 64'd0);
    chk("ar_rel_addr", 64'(bus.address), 64'h80);
    tick();
    chk("ar_idle_wr", 64'(bus.write), 64'd0);
    chk("ar_idle_rd", 64'(bus.read), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
